// File: rtl/vga_fb_ram_pkg.sv
// Shared definitions for the VGA framebuffer RAM: clear-engine state
// encoding and the default framebuffer geometry used to size the array.
package vga_fb_ram_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

    // Current video mode: 640x480, 16 bpp.
    localparam int FB_H_PIX  = 640;
    localparam int FB_V_PIX  = 480;
    localparam int FB_BPP    = 16;
    localparam int FB_WORD_W = 32;

    // The scanout side stores one 32-bit word per 8x8 pixel cell,
    // giving 80 x 60 = 4800 words for the current mode.
    localparam int FB_CELL  = 8;
    localparam int FB_DEPTH = (FB_H_PIX / FB_CELL) * (FB_V_PIX / FB_CELL);

endpackage

// File: rtl/vga_fb_clear.sv
// Hardware clear engine: walks every word once, writing a latched fill
// value through port A, then pulses done.
//   clk, rst        : clock, synchronous active-high reset
//   start_i/value_i : clear request and fill word (sampled when idle)
//   busy_o/done_o   : clear in progress / one-cycle completion pulse
//   en_o, we_o,
//   addr_o, din_o   : port A write request while busy
module vga_fb_clear
    import vga_fb_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NB     = 4,
    parameter int DEPTH  = FB_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] value_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              en_o,
    output logic [NB-1:0]     we_o,
    output logic [IDX_W-1:0]  addr_o,
    output logic [DATA_W-1:0] din_o
);

    clr_state_e        state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] val_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        val_q   <= value_i;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Last word is written on this edge.
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign en_o   = busy_q;
    assign we_o   = {NB{busy_q}};
    assign addr_o = cnt_q;
    assign din_o  = val_q;

endmodule

// File: rtl/vga_fb_ram.sv
// True dual-port framebuffer RAM with byte enables, read-during-write
// mode, optional output register, range checking and a clear engine.
//   Port A (a_*) : CPU/DMA side, shared with the clear engine (a_ready)
//   Port B (b_*) : VGA scanout side, always accepted
//   *_dout/_valid: read data and its strobe, *_err sticky range error
//   clr_*        : clear request, fill value, busy and done pulse
module vga_fb_ram
    import vga_fb_ram_pkg::*;
#(
    parameter int  DATA_W      = 32,
    parameter int  BYTE_W      = 8,
    parameter int  DEPTH       = FB_DEPTH,
    parameter int  ADDR_W      = 32,
    parameter bit  WRITE_FIRST = 1'b0,
    parameter bit  OUT_REG     = 1'b0,
    localparam int NB          = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    output logic              a_ready,
    input  logic [NB-1:0]     a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    output logic              a_err,
    input  logic              b_en,
    input  logic [NB-1:0]     b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    output logic              b_err,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              clr_en;
    logic [NB-1:0]     clr_we;
    logic [IDX_W-1:0]  clr_addr;
    logic [DATA_W-1:0] clr_din;

    vga_fb_clear #(
        .DATA_W (DATA_W),
        .NB     (NB),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .start_i (clr_start),
        .value_i (clr_value),
        .busy_o  (clr_busy),
        .done_o  (clr_done),
        .en_o    (clr_en),
        .we_o    (clr_we),
        .addr_o  (clr_addr),
        .din_o   (clr_din)
    );

    assign a_ready = !clr_busy;

    logic             a_acc, b_acc;
    logic             a_inr, b_inr;
    logic [IDX_W-1:0] a_idx, b_idx;

    // Requests seen while rst is high are not accepted.
    assign a_acc = a_en && a_ready && !rst;
    assign b_acc = b_en && !rst;
    assign a_inr = a_addr < ADDR_W'(DEPTH);
    assign b_inr = b_addr < ADDR_W'(DEPTH);
    assign a_idx = a_addr[IDX_W-1:0];
    assign b_idx = b_addr[IDX_W-1:0];

    // Port A write side: the clear engine owns it while busy.
    logic [IDX_W-1:0]  pa_idx;
    logic [DATA_W-1:0] pa_din;
    logic [NB-1:0]     pa_we;
    logic [NB-1:0]     pb_we;

    always_comb begin
        pa_idx = a_idx;
        pa_din = a_din;
        pa_we  = '0;
        if (clr_en) begin
            pa_idx = clr_addr;
            pa_din = clr_din;
            pa_we  = rst ? '0 : clr_we;
        end else if (a_acc && a_inr) begin
            pa_we = a_we;
        end
    end

    assign pb_we = (b_acc && b_inr) ? b_we : '0;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Port A lanes are written last so they win same-address collisions.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (pb_we[i]) begin
                mem_q[b_idx][i*BYTE_W +: BYTE_W] <= b_din[i*BYTE_W +: BYTE_W];
            end
            if (pa_we[i]) begin
                mem_q[pa_idx][i*BYTE_W +: BYTE_W] <= pa_din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    logic [DATA_W-1:0] a_old, b_old, a_new, b_new;
    logic [DATA_W-1:0] a_rd_d, b_rd_d;

    // New-data view merges only this port's own lanes; the other port's
    // same-cycle write is never visible.
    always_comb begin
        a_old = mem_q[a_idx];
        b_old = mem_q[b_idx];
        a_new = a_old;
        b_new = b_old;
        for (int i = 0; i < NB; i++) begin
            if (a_we[i]) a_new[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
            if (b_we[i]) b_new[i*BYTE_W +: BYTE_W] = b_din[i*BYTE_W +: BYTE_W];
        end
        a_rd_d = '0;
        b_rd_d = '0;
        if (a_inr) a_rd_d = WRITE_FIRST ? a_new : a_old;
        if (b_inr) b_rd_d = WRITE_FIRST ? b_new : b_old;
    end

    logic              a_v1_q, b_v1_q;
    logic [DATA_W-1:0] a_d1_q, b_d1_q;
    logic              a_err_q, b_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_v1_q  <= 1'b0;
            b_v1_q  <= 1'b0;
            a_d1_q  <= '0;
            b_d1_q  <= '0;
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
        end else begin
            a_v1_q <= a_acc;
            b_v1_q <= b_acc;
            if (a_acc) a_d1_q <= a_rd_d;
            if (b_acc) b_d1_q <= b_rd_d;
            if (a_acc && !a_inr) a_err_q <= 1'b1;
            if (b_acc && !b_inr) b_err_q <= 1'b1;
        end
    end

    assign a_err = a_err_q;
    assign b_err = b_err_q;

    if (OUT_REG) begin : g_oreg
        logic              a_v2_q, b_v2_q;
        logic [DATA_W-1:0] a_d2_q, b_d2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_v2_q <= 1'b0;
                b_v2_q <= 1'b0;
                a_d2_q <= '0;
                b_d2_q <= '0;
            end else begin
                a_v2_q <= a_v1_q;
                b_v2_q <= b_v1_q;
                if (a_v1_q) a_d2_q <= a_d1_q;
                if (b_v1_q) b_d2_q <= b_d1_q;
            end
        end

        assign a_valid = a_v2_q;
        assign b_valid = b_v2_q;
        assign a_dout  = a_d2_q;
        assign b_dout  = b_d2_q;
    end else begin : g_noreg
        assign a_valid = a_v1_q;
        assign b_valid = b_v1_q;
        assign a_dout  = a_d1_q;
        assign b_dout  = b_d1_q;
    end

endmodule

// File: tb/tb_vga_fb_ram.sv
// Bench for vga_fb_ram: two instances (old-data/unregistered and
// new-data/registered) driven in lockstep against a word-array model.
module tb_vga_fb_ram;

    localparam int DW = 32;
    localparam int BW = 8;
    localparam int NB = 4;
    localparam int D  = 16;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_en, b_en, clr_start;
    logic [NB-1:0] a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din, clr_value;

    logic          a_ready [2];
    logic [DW-1:0] a_dout [2];
    logic          a_valid [2];
    logic          a_err [2];
    logic [DW-1:0] b_dout [2];
    logic          b_valid [2];
    logic          b_err [2];
    logic          clr_busy [2];
    logic          clr_done [2];

    vga_fb_ram #(
        .DATA_W(DW), .BYTE_W(BW), .DEPTH(D), .ADDR_W(AW),
        .WRITE_FIRST(1'b0), .OUT_REG(1'b0)
    ) u0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_ready(a_ready[0]), .a_we(a_we),
        .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[0]),
        .a_valid(a_valid[0]), .a_err(a_err[0]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout[0]), .b_valid(b_valid[0]), .b_err(b_err[0]),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy[0]), .clr_done(clr_done[0])
    );

    vga_fb_ram #(
        .DATA_W(DW), .BYTE_W(BW), .DEPTH(D), .ADDR_W(AW),
        .WRITE_FIRST(1'b1), .OUT_REG(1'b1)
    ) u1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_ready(a_ready[1]), .a_we(a_we),
        .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[1]),
        .a_valid(a_valid[1]), .a_err(a_err[1]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout[1]), .b_valid(b_valid[1]), .b_err(b_err[1]),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy[1]), .clr_done(clr_done[1])
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model: word array, clear window from its start edge,
    // and the expected outputs of both instances.
    logic [DW-1:0] mm [D];
    int            n  = 0;
    int            t0 = -1000;
    logic [DW-1:0] cval;
    logic [DW-1:0] e_ad [2], e_bd [2];
    logic          e_av [2], e_bv [2];
    logic          s_av, s_bv;
    logic [DW-1:0] s_ad, s_bd;
    logic          e_aerr, e_berr, e_busy, e_done;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                            input logic [DW-1:0] w,
                                            input logic [NB-1:0] we);
        logic [DW-1:0] m;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = we[i] ? 8'hFF : 8'h00;
        return (o & ~m) | (w & m);
    endfunction

    task automatic model_edge();
        bit            busy_b, a_acc, a_in, b_in;
        logic [DW-1:0] ao, an, bo, bn;
        n++;
        if (rst) begin
            t0 = -1000;
            e_ad = '{default: '0};
            e_bd = '{default: '0};
            e_av = '{default: 1'b0};
            e_bv = '{default: 1'b0};
            s_av = 0; s_bv = 0; s_ad = '0; s_bd = '0;
            e_aerr = 0; e_berr = 0; e_busy = 0; e_done = 0;
            return;
        end
        // A clear started at edge t0 writes word k at edge t0+1+k.
        busy_b = (n - t0 >= 1) && (n - t0 <= D);
        a_acc  = a_en && !busy_b;
        a_in   = a_addr < D;
        b_in   = b_addr < D;
        ao = a_in ? mm[a_addr[3:0]] : '0;
        an = a_in ? merge(ao, a_din, a_we) : '0;
        bo = b_in ? mm[b_addr[3:0]] : '0;
        bn = b_in ? merge(bo, b_din, b_we) : '0;
        if (b_en && b_in) mm[b_addr[3:0]] = merge(mm[b_addr[3:0]], b_din, b_we);
        if (busy_b) mm[n - t0 - 1] = cval;
        else if (a_acc && a_in) mm[a_addr[3:0]] = merge(mm[a_addr[3:0]], a_din, a_we);
        if (a_acc && !a_in) e_aerr = 1;
        if (b_en && !b_in) e_berr = 1;
        if (!busy_b && clr_start) begin
            t0   = n;
            cval = clr_value;
        end
        e_busy = (n - t0 >= 0) && (n - t0 <= D - 1);
        e_done = (n - t0 == D);
        e_av[1] = s_av;
        e_bv[1] = s_bv;
        if (s_av) e_ad[1] = s_ad;
        if (s_bv) e_bd[1] = s_bd;
        s_av = a_acc;
        s_bv = b_en;
        if (a_acc) s_ad = an;
        if (b_en) s_bd = bn;
        e_av[0] = a_acc;
        e_bv[0] = b_en;
        if (a_acc) e_ad[0] = ao;
        if (b_en) e_bd[0] = bo;
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("a_dout%0d", k), 64'(a_dout[k]), 64'(e_ad[k]));
            check($sformatf("a_valid%0d", k), 64'(a_valid[k]), 64'(e_av[k]));
            check($sformatf("b_dout%0d", k), 64'(b_dout[k]), 64'(e_bd[k]));
            check($sformatf("b_valid%0d", k), 64'(b_valid[k]), 64'(e_bv[k]));
            check($sformatf("a_err%0d", k), 64'(a_err[k]), 64'(e_aerr));
            check($sformatf("b_err%0d", k), 64'(b_err[k]), 64'(e_berr));
            check($sformatf("busy%0d", k), 64'(clr_busy[k]), 64'(e_busy));
            check($sformatf("done%0d", k), 64'(clr_done[k]), 64'(e_done));
            check($sformatf("ready%0d", k), 64'(a_ready[k]), 64'(!e_busy));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        rst = 0; a_en = 0; b_en = 0; clr_start = 0;
        a_we = '0; b_we = '0;
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
    endtask

    task automatic a_wr(input int ad, input logic [DW-1:0] dat,
                        input logic [NB-1:0] we);
        a_en = 1; a_addr = AW'(ad); a_din = dat; a_we = we;
    endtask

    task automatic b_rd(input int ad);
        b_en = 1; b_addr = AW'(ad); b_we = '0;
    endtask

    int bc, dc, r;

    initial begin
        idle();
        clr_value = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();

        // Define every word before any read.
        clr_start = 1; clr_value = '0;
        tick();
        clr_start = 0;
        for (int i = 0; i < D + 1; i++) tick();

        // Byte-lane merge, seen on port B.
        a_wr(5, 32'hDEADBEEF, 4'b1111); tick();
        a_wr(5, 32'h000000AA, 4'b0001); tick();
        idle(); b_rd(5); tick();
        check("merge_lat1", 64'(b_dout[0]), 64'h0000_0000_DEAD_BEAA);
        idle(); tick();
        check("merge_lat2", 64'(b_dout[1]), 64'h0000_0000_DEAD_BEAA);
        check("merge_lat2_v", 64'(b_valid[1]), 64'd1);

        // Same-address writes from both ports.
        a_wr(9, 32'h11111111, 4'b0011);
        b_en = 1; b_addr = 9; b_din = 32'h22222222; b_we = 4'b0110;
        tick();
        idle(); b_rd(9); tick();
        check("collide", 64'(b_dout[0]), 64'h0000_0000_0022_1111);

        // Read-during-write on port A.
        idle(); a_wr(3, 32'h1, 4'hF); tick();
        a_wr(3, 32'h2, 4'hF); tick();
        check("rdw_old", 64'(a_dout[0]), 64'd1);
        idle(); tick();
        check("rdw_new", 64'(a_dout[1]), 64'd2);

        // Out-of-range accesses.
        b_rd(D); tick();
        check("oor_b_dout", 64'(b_dout[0]), 64'd0);
        check("oor_b_valid", 64'(b_valid[0]), 64'd1);
        check("oor_b_err", 64'(b_err[0]), 64'd1);
        idle(); a_wr(5000, 32'hCAFEF00D, 4'hF); tick();
        check("oor_a_err", 64'(a_err[0]), 64'd1);
        idle(); b_rd(5000 % D); tick();

        // Full clear with port B reads and ignored port A requests.
        idle();
        clr_start = 1; clr_value = 32'h0F0F0F0F;
        tick();
        bc = int'(clr_busy[0]);
        dc = 0;
        clr_start = 0;
        for (int i = 0; i < 20; i++) begin
            a_en   = (i < 14);
            a_addr = AW'($urandom_range(0, D + 3));
            a_din  = $urandom;
            a_we   = 4'hF;
            b_rd($urandom_range(0, D - 1));
            clr_start = (i == 4);
            tick();
            bc += int'(clr_busy[0]);
            dc += int'(clr_done[0]);
        end
        check("clr_busy_cycles", 64'(bc), 64'(D));
        check("clr_done_pulses", 64'(dc), 64'd1);
        idle();
        for (int k = 0; k < D; k++) begin
            b_rd(k); tick();
            check("clr_word", 64'(b_dout[0]), 64'h0000_0000_0F0F_0F0F);
        end

        // Reset in the middle of a clear.
        idle();
        clr_start = 1; clr_value = 32'h55AA55AA;
        tick();
        clr_start = 0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1; tick();
        check("abort_busy", 64'(clr_busy[0]), 64'd0);
        check("abort_done", 64'(clr_done[0]), 64'd0);
        rst = 0;
        for (int k = 0; k < D; k++) begin
            b_rd(k); tick();
            check("abort_word", 64'(b_dout[0]),
                  (k < 8) ? 64'h0000_0000_55AA_55AA : 64'h0000_0000_0F0F_0F0F);
        end

        // Random traffic.
        idle();
        for (int i = 0; i < 800; i++) begin
            a_en = 1'($urandom_range(0, 1));
            b_en = 1'($urandom_range(0, 1));
            a_we = 4'($urandom);
            b_we = 4'($urandom);
            a_din = $urandom;
            b_din = $urandom;
            r = $urandom_range(0, D + 3);
            a_addr = (r == D + 3) ? 32'hFFFF_FFF0 : AW'(r);
            r = $urandom_range(0, D + 3);
            b_addr = (r == D + 3) ? 32'h8000_0004 : AW'(r);
            clr_start = ($urandom_range(0, 59) == 0);
            clr_value = $urandom;
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
